// File: rtl/conv_pkg.sv
// conv_pkg: shared helpers for the narrow/wide converters.
//   lane_idx : maps a beat index within a word to its lane number,
//              honouring the lane order selected by msb_first.
//   keep_hit : keep-mask helper; 1 when mask bit k belongs to the given lane.
package conv_pkg;

    // Beat i lands in the top lane first when msb_first is set,
    // otherwise it lands in lane i.
    function automatic int unsigned lane_idx(input int unsigned i,
                                             input int unsigned ratio,
                                             input bit          msb_first);
        return msb_first ? (ratio - 1 - i) : i;
    endfunction

    function automatic logic keep_hit(input int unsigned k,
                                      input int unsigned lane);
        return (k == lane);
    endfunction

endpackage

// File: rtl/conv_out_reg.sv
// conv_out_reg: single-entry valid/ready holding register.
//   clk, reset    : clock, synchronous active-high reset
//   load          : capture load_data this cycle (only legal when can_load=1)
//   load_data [W] : payload to capture
//   out_ready     : downstream accepts the held payload
//   can_load      : register is empty or is being drained this cycle
//   out_valid     : payload present
//   out_data [W]  : held payload, stable while out_valid && !out_ready
// Handshake: a payload transfers on any cycle where out_valid && out_ready.
// A load in the same cycle as a drain replaces the payload with no bubble.
module conv_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         can_load,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        can_load = !valid_q || out_ready;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/conv_narrow_wide.sv
// conv_narrow_wide: packs RATIO beats of IN_W bits into one OUT_W word.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input beat handshake (beat taken when both high)
//   in_data [IN_W]        : input beat
//   in_last               : this beat closes the current word
//   flush                 : close the pending partial word without a beat
//   out_valid/out_ready   : output word handshake (word taken when both high)
//   out_data [OUT_W]      : packed word, lane k at [k*IN_W +: IN_W]
//   out_keep [RATIO]      : bit k set when lane k holds a beat
//   out_last              : word was closed by in_last or flush
// Handshake: each side transfers on a cycle where valid && ready; in_ready
// is combinational from out_ready so a held word and a new beat can swap
// in one cycle.
module conv_narrow_wide
    import conv_pkg::*;
#(
    parameter  int IN_W      = 8,
    parameter  int RATIO     = 4,
    parameter  int MSB_FIRST = 1,
    localparam int OUT_W     = IN_W * RATIO,
    localparam int CW        = $clog2(RATIO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [RATIO-1:0] out_keep,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int PW = OUT_W + RATIO + 1;

    logic [OUT_W-1:0] acc_q,  acc_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic [CW-1:0]    cnt_q,  cnt_d;

    logic             can_load;
    logic             accept;
    logic             at_end;
    logic             load;
    logic [CW-1:0]    lane;
    logic [RATIO-1:0] lane_keep;
    logic [OUT_W-1:0] word_data;
    logic [RATIO-1:0] word_keep;
    logic             word_last;
    logic [PW-1:0]    held;

    always_comb begin
        lane = CW'(lane_idx(32'(cnt_q), RATIO, MSB_FIRST != 0));
        lane_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            lane_keep[k] = keep_hit(k, 32'(lane));
        end
    end

    always_comb begin
        in_ready  = can_load && !reset;
        accept    = in_valid && in_ready;
        at_end    = (cnt_q == CW'(RATIO - 1));
        acc_d     = acc_q;
        keep_d    = keep_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        word_data = acc_q;
        word_keep = keep_q;
        word_last = 1'b1;
        if (accept) begin
            word_data[int'(lane)*IN_W +: IN_W] = in_data;
            word_keep = keep_q | lane_keep;
            if (at_end || in_last || flush) begin
                load      = 1'b1;
                // A word that merely filled up is not "last" unless the
                // source also marked it so.
                word_last = !at_end || in_last || flush;
                acc_d     = '0;
                keep_d    = '0;
                cnt_d     = '0;
            end else begin
                acc_d  = word_data;
                keep_d = word_keep;
                cnt_d  = cnt_q + 1'b1;
            end
        end else if (flush && (cnt_q != '0) && can_load && !reset) begin
            // Bare flush: emit what is accumulated; empty words never go out.
            load   = 1'b1;
            acc_d  = '0;
            keep_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            keep_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            keep_q <= keep_d;
            cnt_q  <= cnt_d;
        end
    end

    conv_out_reg #(.W(PW)) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data ({word_last, word_keep, word_data}),
        .out_ready (out_ready),
        .can_load  (can_load),
        .out_valid (out_valid),
        .out_data  (held)
    );

    assign out_data = held[OUT_W-1:0];
    assign out_keep = held[OUT_W +: RATIO];
    assign out_last = held[PW-1];

endmodule

// File: tb/tb_conv_narrow_wide.sv
// Bench for conv_narrow_wide: two instances (MSB-first and LSB-first lane
// order) share all inputs and are compared each cycle against a model that
// keeps the accepted beats of a word as a list and packs them on demand.
module tb_conv_narrow_wide;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int OUT_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             in_valid, in_last, flush, out_ready;
    logic [IN_W-1:0]  in_data;

    logic             rdy_m, ov_m, ol_m;
    logic [OUT_W-1:0] od_m;
    logic [RATIO-1:0] ok_m;
    logic             rdy_l, ov_l, ol_l;
    logic [OUT_W-1:0] od_l;
    logic [RATIO-1:0] ok_l;

    conv_narrow_wide #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_m), .flush(flush),
        .out_valid(ov_m), .out_data(od_m), .out_keep(ok_m),
        .out_last(ol_m), .out_ready(out_ready)
    );

    conv_narrow_wide #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_l), .flush(flush),
        .out_valid(ov_l), .out_data(od_l), .out_keep(ok_l),
        .out_last(ol_l), .out_ready(out_ready)
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n_words = 0;

    logic [IN_W-1:0] acc_beats[$];   // beats accepted into the open word
    logic [IN_W-1:0] exp_q[$];       // beats of the word the output should hold
    bit              m_valid = 1'b0;
    bit              m_last  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void pack_held(input bit msb, output logic [OUT_W-1:0] d,
                                      output logic [RATIO-1:0] k);
        d = '0;
        k = '0;
        foreach (exp_q[i]) begin
            int lane;
            lane = msb ? (RATIO - 1 - i) : i;
            d[lane*IN_W +: IN_W] = exp_q[i];
            k[lane] = 1'b1;
        end
    endfunction

    task automatic model_update();
        bit rdy;
        bit load;
        bit lst;
        load = 1'b0;
        lst  = 1'b0;
        if (reset) begin
            acc_beats.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_last  = 1'b0;
        end else begin
            rdy = !m_valid || out_ready;
            if (in_valid && rdy) begin
                acc_beats.push_back(in_data);
                if (acc_beats.size() == RATIO || in_last || flush) begin
                    load = 1'b1;
                    lst  = (acc_beats.size() < RATIO) || in_last || flush;
                end
            end else if (flush && acc_beats.size() > 0 && rdy) begin
                load = 1'b1;
                lst  = 1'b1;
            end
            if (load) begin
                exp_q   = acc_beats;
                acc_beats.delete();
                m_valid = 1'b1;
                m_last  = lst;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic step();
        logic [OUT_W-1:0] d;
        logic [RATIO-1:0] k;
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !reset && (!m_valid || out_ready);
        check("in_ready_msb", 64'(rdy_m), 64'(exp_rdy));
        check("in_ready_lsb", 64'(rdy_l), 64'(exp_rdy));
        check("out_valid_msb", 64'(ov_m), 64'(m_valid));
        check("out_valid_lsb", 64'(ov_l), 64'(m_valid));
        if (m_valid) begin
            pack_held(1'b1, d, k);
            check("data_msb", 64'(od_m), 64'(d));
            check("keep_msb", 64'(ok_m), 64'(k));
            check("last_msb", 64'(ol_m), 64'(m_last));
            pack_held(1'b0, d, k);
            check("data_lsb", 64'(od_l), 64'(d));
            check("keep_lsb", 64'(ok_l), 64'(k));
            check("last_lsb", 64'(ol_l), 64'(m_last));
        end
        if (ov_m && out_ready) n_words++;
        model_update();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [IN_W-1:0] d, input bit l,
                         input bit f, input bit r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        flush     = f;
        out_ready = r;
    endtask

    task automatic beat(input logic [IN_W-1:0] d, input bit l);
        drive(1'b1, d, l, 1'b0, 1'b1);
        step();
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ov_m), 64'd0);
        check("rst_out_data", 64'(od_m), 64'd0);
        check("rst_out_keep", 64'(ok_m), 64'd0);
        check("rst_out_last", 64'(ol_m), 64'd0);
        check("rst_in_ready", 64'(rdy_m), 64'd0);
        reset = 1'b0;

        // full word in both lane orders
        beat(8'h0F, 1'b0); beat(8'h0D, 1'b0); beat(8'h03, 1'b0); beat(8'hA5, 1'b0);
        check("t1_data_msb", 64'(od_m), 64'h0F0D03A5);
        check("t1_data_lsb", 64'(od_l), 64'hA5030D0F);
        check("t1_keep", 64'(ok_m), 64'hF);
        check("t1_last", 64'(ol_m), 64'd0);
        idle();

        // partial word closed by in_last, then a new word starts at lane 3
        beat(8'h11, 1'b0); beat(8'h22, 1'b1);
        check("t3_data_msb", 64'(od_m), 64'h11220000);
        check("t3_data_lsb", 64'(od_l), 64'h00002211);
        check("t3_keep", 64'(ok_m), 64'hC);
        check("t3_last", 64'(ol_m), 64'd1);
        beat(8'h33, 1'b1);
        check("t3_next_word", 64'(od_m), 64'h33000000);
        idle();

        // backpressure
        do_reset();
        beat(8'hA1, 1'b0); beat(8'hA2, 1'b0); beat(8'hA3, 1'b0); beat(8'hA4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
            step();
            check("t4_in_ready", 64'(rdy_m), 64'd0);
            check("t4_stable", 64'(od_m), 64'hA1A2A3A4);
        end
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        step();
        check("t4_drained", 64'(ov_m), 64'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        check("t4_pending_beat", 64'(od_m), 64'h77000000);
        idle();

        // flush
        do_reset();
        beat(8'h44, 1'b0); beat(8'h55, 1'b0); beat(8'h66, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        check("t5_data", 64'(od_m), 64'h44556600);
        check("t5_keep", 64'(ok_m), 64'hE);
        check("t5_last", 64'(ol_m), 64'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        check("t5_empty_flush", 64'(ov_m), 64'd0);

        // reset mid-word
        beat(8'h0F, 1'b0); beat(8'h0D, 1'b0);
        do_reset();
        w0 = n_words;
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
        check("t6_data", 64'(od_m), 64'h01020304);
        idle();
        idle();
        check("t6_word_count", 64'(n_words - w0), 64'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0;
        repeat (4) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_narrow_wide.md
Name: conv_narrow_wide

Overview:
Parametrised narrow-to-wide packer, the single-clock successor of the 8-to-32 converter. It accumulates RATIO beats of IN_W bits into one IN_W*RATIO word and emits it on a valid/ready output stage. Beyond the fixed 8→32 block, it adds:
- selectable lane order;
- partial-word termination via in_last or flush, with a lane keep mask;
- full backpressure.

It sits between the byte-wide link front end and the word-wide datapath.

Parameters:
- IN_W, 8, width of one input beat in bits (≥1).
- RATIO, 4, beats per output word (≥2).
- MSB_FIRST, 1, 1 = first beat lands in the top lane; 0 = first beat lands in lane 0.
- OUT_W is derived as IN_W*RATIO and is not overridable. CW = $clog2(RATIO).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_data  in  IN_W  input beat.
- in_last  in  1  beat terminates the current word.
- in_ready  out  1  block can accept a beat this cycle.
- flush  in  1  emit the pending partial word without a new beat.
- out_valid  out  1  output word present.
- out_data  out  OUT_W  packed word.
- out_keep  out  RATIO  bit k = lane k holds a valid beat.
- out_last  out  1  word ended by in_last or flush (not by filling).
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Lane k occupies out_data[k*IN_W +: IN_W].
- Beat index i (0-based within a word) targets lane RATIO-1-i if MSB_FIRST=1, otherwise lane i.
- State: acc (OUT_W), acc_keep (RATIO), cnt (CW bits, 0..RATIO-1), output register {out_data, out_keep, out_last, out_valid}.
- Reset value (sync): cnt=0, acc=0, acc_keep=0, out_valid=0, out_data=0, out_keep=0, out_last=0.
- Reset mid-operation: the partial accumulation and any held output word are discarded. Nothing is emitted afterwards.
- in_ready = !out_valid || out_ready. This is combinational from out_ready. in_ready is 0 while reset is high.
- Accept = in_valid && in_ready. in_data is ignored when not accepted.
- Completion: an accepted beat completes the word if cnt==RATIO-1, in_last=1, or flush=1 in the same cycle.
- On completion, the output register loads {acc merged with the beat, keep incl. this lane, out_last = (cnt!=RATIO-1) || in_last || flush}. Then cnt←0, acc←0, acc_keep←0.
- A word completed by filling that also has in_last=1 gets out_last=1.
- On a non-completing accept: write the lane, set its keep bit, cnt←cnt+1.
- flush without accept, with cnt>0 and (!out_valid || out_ready): emit acc as a partial word with out_last=1, then clear the accumulator.
- flush with cnt==0 and no beat: no effect. No empty words are ever emitted.
- flush while the output is blocked: ignored (not remembered). The source must hold flush until it is honoured.
- Latency: completing beat at edge N → out_valid=1 in the cycle after edge N.
- Throughput: one beat per cycle; one word per RATIO cycles when out_ready=1 continuously.
- Output stage:
  - out_valid clears on out_ready if no new word loads the same cycle.
  - Simultaneous drain and load: the new word replaces the old with no bubble, and out_valid stays 1.
  - While out_valid && !out_ready, out_data, out_keep and out_last are stable.
- Unused lanes of a partial word read 0.

Decomposition:
- Package conv_pkg: lane_idx(i, MSB_FIRST) function and a keep-mask helper. No typedefs beyond these.
- One sub-module: conv_out_reg, the valid/ready holding register (width parameter), reused by later wide-to-narrow work.
- The accumulator and counter stay in the top module.

Test Plan:
All scenarios use IN_W=8 and RATIO=4.
1. Full word, MSB_FIRST=1: beats 0F,0D,03,A5 on 4 consecutive cycles, out_ready=1 → next cycle out_data=0x0F0D03A5, out_keep=1111, out_last=0, in_ready held 1 throughout.
2. Lane order, MSB_FIRST=0: same beats → out_data=0xA5030D0F, keep=1111.
3. Partial word: beats 11, 22 with in_last on 22 → out_data=0x11220000, keep=1100, out_last=1. The next beat 33 starts a new word in lane 3.
4. Backpressure: out_ready=0 after a word is emitted → out_data stable and in_ready=0 for 5 cycles. Beats offered meanwhile are not consumed. Raising out_ready drains the word and accepts the pending beat in the same cycle.
5. Flush: beats 44, 55, 66, then flush alone → 0x44556600, keep=1110, out_last=1. A second flush with cnt=0 → no out_valid.
6. Reset mid-word: beats 0F, 0D, then reset high for 1 cycle, then beats 01,02,03,04 → exactly one word, 0x01020304. out_valid never asserts with 0F/0D content.
